// File: rtl/lcd_capture.sv
// Captures the PPU's 2bpp LCD stream, packs 8 pixels per framebuffer word and queues them in a show-ahead FIFO.
// Optional double-buffered addressing is enabled by defining LCD_CAPTURE_DOUBLE_BUFFER_EN.
module lcd_capture #(
    parameter int unsigned H_PIXELS   = 160,
    parameter int unsigned V_LINES    = 144,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic        cpl,
    input  logic [1:0]  pixel,
    input  logic        valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_addr,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        overflow,
    output logic        sync_err,
    input  logic        clear_err,
    output logic [7:0]  frame_count,
    output logic        bank
);

    localparam int unsigned XW = $clog2(H_PIXELS);
    localparam int unsigned YW = $clog2(V_LINES + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [XW-1:0] X_LAST      = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(V_LINES - 1);
    localparam logic [YW-1:0] Y_END       = YW'(V_LINES);
    localparam logic [15:0]   WPL         = 16'(H_PIXELS / 8);
    localparam logic [15:0]   FRAME_WORDS = 16'(H_PIXELS / 8 * V_LINES);
    localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {WAIT_VS, ACTIVE} state_t;

    state_t state, state_nx;

    logic cpl_q, hs_q, vs_q;
    logic cap_evt, hs_fall, vs_fall;
    logic in_active, take_pixel, line_abort;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [15:0]   shreg;
    logic [15:0]   word_full;
    logic [15:0]   word_addr;
    logic [15:0]   bank_off;
    logic          word_done;
    logic          wbank;

    logic          push_v;
    logic [15:0]   push_data;
    logic [15:0]   push_addr;
    logic          push_last;

    logic [15:0]   mem_data [FIFO_DEPTH];
    logic [15:0]   mem_addr [FIFO_DEPTH];
    logic          mem_last [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, pop, push_ok, drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            cpl_q <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            cpl_q <= cpl;
            hs_q  <= hs;
            vs_q  <= vs;
        end
    end

    assign cap_evt = cpl & ~cpl_q & valid;
    assign hs_fall = ~hs & hs_q;
    assign vs_fall = ~vs & vs_q;

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_VS;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            WAIT_VS: if (vs_fall) state_nx = ACTIVE;
            ACTIVE:  state_nx = ACTIVE;
            default: state_nx = WAIT_VS;
        endcase
    end

    // vs_fall pre-empts everything; a mid-line hs_fall pre-empts a coincident capture.
    always_comb begin
        in_active  = (state == ACTIVE);
        line_abort = in_active & ~vs_fall & hs_fall & (x != '0);
        take_pixel = in_active & ~vs_fall & ~line_abort & cap_evt & (y < Y_END);
    end

`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wbank <= 1'b0;
            bank  <= 1'b0;
        end else if (vs_fall && in_active) begin
            wbank <= ~wbank;
            bank  <= wbank;
        end
    end
    assign bank_off = wbank ? FRAME_WORDS : '0;
`else
    assign wbank    = 1'b0;
    assign bank     = 1'b0;
    assign bank_off = wbank ? FRAME_WORDS : '0;
`endif

    assign word_full = {shreg[13:0], pixel};
    assign word_done = take_pixel & (x[2:0] == 3'd7);
    assign word_addr = BASE_ADDR + 16'(y) * WPL + 16'(x >> 3) + bank_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            x     <= '0;
            y     <= '0;
            shreg <= '0;
        end else if (vs_fall) begin
            x     <= '0;
            y     <= '0;
            shreg <= '0;
        end else if (line_abort) begin
            x     <= '0;
            y     <= y + 1'b1;
            shreg <= '0;
        end else if (take_pixel) begin
            shreg <= word_full;
            if (x == X_LAST) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) push_v <= 1'b0;
        else     push_v <= word_done;
    end

    always_ff @(posedge clk) begin
        push_data <= word_full;
        push_addr <= word_addr;
        push_last <= (y == Y_LAST) && (x == X_LAST);
    end

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign pop     = ~empty & out_ready;
    assign push_ok = push_v & (~full | pop);
    assign drop    = push_v & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= push_data;
            mem_addr[wr_ptr] <= push_addr;
            mem_last[wr_ptr] <= push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem_data[rd_ptr];
    assign out_addr  = empty ? '0 : mem_addr[rd_ptr];
    assign out_last  = empty ? 1'b0 : mem_last[rd_ptr];

    // Set events take precedence over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow    <= 1'b0;
            sync_err    <= 1'b0;
            frame_count <= '0;
        end else begin
            if (drop)           overflow <= 1'b1;
            else if (clear_err) overflow <= 1'b0;
            if (line_abort)     sync_err <= 1'b1;
            else if (clear_err) sync_err <= 1'b0;
            if (vs_fall)        frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_capture.sv
// Randomised self-checking bench for lcd_capture against a pixel-level reference model.
module tb_lcd_capture;

    localparam int H   = 160;
    localparam int V   = 144;
    localparam int WPL = H / 8;
    localparam int FW  = WPL * V;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs = 1'b1, vs = 1'b1, cpl = 1'b0, valid = 1'b0;
    logic [1:0]  pixel = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [15:0] out_addr, out_data;
    logic        out_last, overflow, sync_err;
    logic        clear_err = 1'b0;
    logic [7:0]  frame_count;
    logic        bank;

    always #5 clk = ~clk;

    lcd_capture #(
        .H_PIXELS(H),
        .V_LINES(V),
        .FIFO_DEPTH(16),
        .BASE_ADDR(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .cpl(cpl), .pixel(pixel), .valid(valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .out_last(out_last), .overflow(overflow), .sync_err(sync_err), .clear_err(clear_err),
        .frame_count(frame_count), .bank(bank)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        last;
    } word_t;

    word_t exp_q[$];
    word_t seen[$];
    word_t mon_e, mon_w, first_w, last_w;

    int n_checks = 0;
    int n_errors = 0;

    bit m_active, m_wbank, m_bank, m_sync_err, rand_ready;
    int m_x, m_y, m_word, m_frames;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_w.addr = out_addr;
            mon_w.data = out_data;
            mon_w.last = out_last;
            if (exp_q.size() == 0) begin
                check_val("pop_no_expected", 32'(out_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("word_addr", 32'(out_addr), 32'(mon_e.addr));
                check_val("word_data", 32'(out_data), 32'(mon_e.data));
                check_val("word_last", 32'(out_last), 32'(mon_e.last));
            end
            seen.push_back(mon_w);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic model_reset();
        m_active = 0; m_wbank = 0; m_bank = 0; m_sync_err = 0;
        m_x = 0; m_y = 0; m_word = 0; m_frames = 0;
        exp_q.delete();
    endtask

    task automatic model_cap(input logic [1:0] p);
        word_t e;
        if (m_active && m_y < V) begin
            m_word = ((m_word << 2) | int'(p)) & 16'hFFFF;
            if (m_x % 8 == 7) begin
                e.addr = 16'(m_y * WPL + m_x / 8 + (m_wbank ? FW : 0));
                e.data = 16'(m_word);
                e.last = (m_y == V - 1) && (m_x == H - 1);
                exp_q.push_back(e);
            end
            m_x++;
            if (m_x == H) begin
                m_x = 0;
                m_y++;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1; hs = 1; vs = 1; cpl = 0; valid = 0; clear_err = 0;
        tick(); tick();
        rst = 0;
        model_reset();
    endtask

    task automatic cap(input logic [1:0] p, input logic v);
        cpl = 1; valid = v; pixel = p;
        tick();
        if (v) model_cap(p);
        cpl = 0; valid = 0;
        tick();
    endtask

    task automatic vsync();
        vs = 0;
        tick();
        m_frames++;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
        if (m_active) begin
            m_bank  = m_wbank;
            m_wbank = !m_wbank;
        end
`endif
        m_active = 1; m_x = 0; m_y = 0; m_word = 0;
        vs = 1;
        tick();
    endtask

    task automatic hsync();
        hs = 0;
        tick();
        if (m_active && m_x != 0) begin
            m_sync_err = 1; m_x = 0; m_y++; m_word = 0;
        end
        hs = 1;
        tick();
    endtask

    task automatic pulse_clear();
        clear_err = 1;
        tick();
        clear_err = 0;
        m_sync_err = 0;
    endtask

    task automatic drain();
        rand_ready = 0;
        out_ready = 1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        tick(); tick();
        check_val("drain_left", 32'(exp_q.size()), 32'd0);
        check_val("drain_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic grab_ends();
        first_w = (seen.size() > 0) ? seen[0] : '0;
        last_w  = (seen.size() > 0) ? seen[seen.size() - 1] : '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lasts;

        // Reset state and pre-sync captures
        rand_ready = 0;
        out_ready = 1;
        do_reset();
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_fc", 32'(frame_count), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);
        check_val("rst_serr", 32'(sync_err), 32'd0);
        check_val("rst_bank", 32'(bank), 32'd0);
        check_val("rst_data", 32'({out_addr, out_data}), 32'd0);
        for (int i = 0; i < 40; i++) cap(2'($urandom_range(0, 3)), 1'b1);
        tick(); tick(); tick();
        check_val("prevs_valid", 32'(out_valid), 32'd0);
        check_val("prevs_fc", 32'(frame_count), 32'd0);
        vsync();
        check_val("vs_fc", 32'(frame_count), 32'd1);

        // Full frame with cycling pixels, then surplus captures that must be dropped
        seen.delete();
        for (int i = 0; i < H * V; i++) cap(2'(i % 4), 1'b1);
        for (int i = 0; i < 16; i++) cap(2'($urandom_range(0, 3)), 1'b1);
        drain();
        grab_ends();
        lasts = 0;
        foreach (seen[i]) if (seen[i].last) lasts++;
        check_val("frame_words", 32'(seen.size()), 32'd2880);
        check_val("frame_first_addr", 32'(first_w.addr), 32'h0000);
        check_val("frame_first_data", 32'(first_w.data), 32'h1B1B);
        check_val("frame_last_addr", 32'(last_w.addr), 32'd2879);
        check_val("frame_last_flag", 32'(last_w.last), 32'd1);
        check_val("frame_last_count", 32'(lasts), 32'd1);
        check_val("frame_ovf", 32'(overflow), 32'd0);

        // Second frame addressing and bank output
        vsync();
        check_val("bank_after_f1", 32'(bank), 32'd0);
        seen.delete();
        for (int i = 0; i < 8; i++) cap(2'($urandom_range(0, 3)), 1'b1);
        drain();
        grab_ends();
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
        check_val("f2_first_addr", 32'(first_w.addr), 32'd2880);
`else
        check_val("f2_first_addr", 32'(first_w.addr), 32'd0);
`endif
        vsync();
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
        check_val("bank_after_f2", 32'(bank), 32'd1);
`else
        check_val("bank_after_f2", 32'(bank), 32'd0);
`endif

        // Overflow: 17 words into a 16-deep FIFO with no consumer
        seen.delete();
        out_ready = 0;
        for (int i = 0; i < 17 * 8; i++) cap(2'($urandom_range(0, 3)), 1'b1);
        tick(); tick(); tick();
        check_val("ovf_set", 32'(overflow), 32'd1);
        check_val("ovf_valid", 32'(out_valid), 32'd1);
        if (exp_q.size() > 16) exp_q.delete(16);
        drain();
        check_val("ovf_held", 32'(seen.size()), 32'd16);
        seen.delete();
        for (int i = 0; i < 8; i++) cap(2'($urandom_range(0, 3)), 1'b1);
        drain();
        grab_ends();
        check_val("ovf_next_addr", 32'(first_w.addr), 32'd17);
        check_val("ovf_sticky", 32'(overflow), 32'd1);

        // Line sync error
        pulse_clear();
        check_val("clr_ovf", 32'(overflow), 32'd0);
        check_val("clr_serr0", 32'(sync_err), 32'd0);
        vsync();
        hsync();
        check_val("hs_at_x0", 32'(sync_err), 32'd0);
        seen.delete();
        for (int i = 0; i < 5; i++) cap(2'($urandom_range(0, 3)), 1'b1);
        hsync();
        check_val("hs_mid_line", 32'(sync_err), 32'd1);
        for (int i = 0; i < 8; i++) cap(2'($urandom_range(0, 3)), 1'b1);
        drain();
        grab_ends();
        check_val("hs_next_addr", 32'(first_w.addr), 32'(20 + (m_wbank ? FW : 0)));
        pulse_clear();
        check_val("clr_serr", 32'(sync_err), 32'd0);

        // Push into a full FIFO while the head is popped
        vsync();
        seen.delete();
        out_ready = 0;
        for (int i = 0; i < 16 * 8 + 7; i++) cap(2'($urandom_range(0, 3)), 1'b1);
        cpl = 1; valid = 1; pixel = 2'($urandom_range(0, 3));
        tick();
        model_cap(pixel);
        cpl = 0; valid = 0; out_ready = 1;
        tick();
        out_ready = 0;
        tick(); tick();
        check_val("full_pop_ovf", 32'(overflow), 32'd0);
        check_val("full_pop_valid", 32'(out_valid), 32'd1);
        drain();
        check_val("full_pop_total", 32'(seen.size()), 32'd17);

        // Randomised traffic with a stalling consumer
        vsync();
        rand_ready = 1;
        for (int i = 0; i < 700; i++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r == 0)      hsync();
            else if (r == 1) cap(2'($urandom_range(0, 3)), 1'b0);
            else if (r == 2) vsync();
            else             cap(2'($urandom_range(0, 3)), 1'b1);
        end
        drain();
        check_val("rand_serr", 32'(sync_err), 32'(m_sync_err));
        check_val("rand_ovf", 32'(overflow), 32'd0);
        check_val("rand_fc", 32'(frame_count), 32'(m_frames & 255));
        check_val("rand_bank", 32'(bank), 32'(m_bank));

        // Reset mid-frame: no partial frame and capture blocked until vs
        for (int i = 0; i < 4; i++) cap(2'($urandom_range(0, 3)), 1'b1);
        do_reset();
        check_val("mid_rst_fc", 32'(frame_count), 32'd0);
        for (int i = 0; i < 8; i++) cap(2'($urandom_range(0, 3)), 1'b1);
        tick(); tick(); tick();
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_serr", 32'(sync_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lcd_capture.md
Name: lcd_capture

Overview:
- Sits directly downstream of the PPU's LCD output port (hs, vs, cpl, pixel, valid).
- Samples the 2bpp pixel stream, packs 8 pixels into a 16-bit word, tags each word with its framebuffer word address, and buffers words in a show-ahead FIFO.
- The FIFO is drained through a valid/ready port by a platform framebuffer writer.
- Runs entirely in the 4.19 MHz clk domain of the core.

Parameters:
- H_PIXELS, 160, pixels per line; must be a multiple of 8.
- V_LINES, 144, lines per frame.
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.
- BASE_ADDR, 16'h0000, word address of pixel (0,0).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- hs  in  1  horizontal sync from PPU, active-low.
- vs  in  1  vertical sync from PPU, active-low.
- cpl  in  1  pixel latch from PPU.
- pixel  in  2  pixel data.
- valid  in  1  pixel qualifier.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_addr  out  16  word address of head.
- out_data  out  16  8 packed pixels; first pixel in [15:14].
- out_last  out  1  head is the final word of a frame.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- sync_err  out  1  sticky: hs arrived mid-line.
- clear_err  in  1  clears overflow and sync_err.
- frame_count  out  8  vs falling edges seen; wraps.
- bank  out  1  bank of the last completed frame (see Optional Feature).

Behaviour:
- Reset values:
  - All outputs 0; FIFO empty.
  - x = 0, y = 0, shift register cleared, state = WAIT_VS.
  - cpl_q = 0, hs_q = 1, vs_q = 1.
- Edge detection uses registered copies cpl_q, hs_q, vs_q:
  - Capture event: cpl & ~cpl_q & valid. pixel is sampled on that same posedge.
  - hs_fall: ~hs & hs_q. vs_fall: ~vs & vs_q.
- State machine:
  - WAIT_VS: capture events are ignored. On vs_fall go to ACTIVE.
  - ACTIVE: capture events are processed.
  - rst mid-frame returns to WAIT_VS, so no partial frame is emitted.
- Every vs_fall, in either state:
  - x = 0, y = 0, shift register cleared.
  - frame_count++, wrapping 255 -> 0.
  - vs_fall has priority over a simultaneous capture event or hs_fall.
- Capture event in ACTIVE with y < V_LINES:
  - Pixel shifts into the word at position x mod 8.
  - x++.
  - When x mod 8 == 7, the completed word is pushed with:
    - addr = BASE_ADDR + y*(H_PIXELS/8) + x/8, using 16-bit arithmetic that truncates.
    - last = (y == V_LINES-1) && (x == H_PIXELS-1).
  - When x == H_PIXELS-1: x = 0 and y++.
- Capture events with y >= V_LINES are dropped silently; counters hold.
- hs_fall in ACTIVE:
  - If x != 0: sync_err = 1, partial word discarded, x = 0, y++.
  - If x == 0: no effect.
- FIFO:
  - Show-ahead; out_valid = ~empty; out_data, out_addr and out_last are driven from the head entry.
  - A pop occurs when out_valid & out_ready.
  - Push when not full: stored.
  - Push when full with a simultaneous pop: stored, count unchanged, no overflow.
  - Push when full without a pop: word dropped, overflow = 1. Addressing continues, so later words keep correct addresses.
- Latency: a word is written on the posedge after the posedge that samples its 8th pixel. out_valid is high in the cycle after that write, when the FIFO was empty.
- clear_err: clears overflow and sync_err next cycle. A simultaneous set event wins over the clear.

Optional Feature:
- Macro: LCD_CAPTURE_DOUBLE_BUFFER_EN.
- With the macro:
  - A write bank bit toggles on every vs_fall that occurs in ACTIVE.
  - Word address adds wbank*(H_PIXELS/8)*V_LINES.
  - bank output = ~wbank, the last completed bank. It updates on the same vs_fall.
- Without the macro:
  - Single buffer; no bank offset; bank tied to 0.

Test Plan:
1. Reset, then 40 capture events before any vs_fall -> out_valid stays 0 and frame_count = 0. Then vs_fall -> frame_count = 1.
2. vs_fall, then a full 160x144 frame with pixels cycling 0,1,2,3 and out_ready = 1:
   - Exactly 2880 words.
   - First word addr 0x0000, data 16'h1B1B.
   - Last word addr 2879 (0x0B3F) with out_last = 1; out_last = 0 on every other word.
3. out_ready = 0, FIFO_DEPTH = 16, push 17 words:
   - overflow = 1, 16 entries held.
   - After draining, the next word carries addr 17 (word 16 lost).
4. hs_fall at x = 5 on line 0 -> sync_err = 1; the next pushed word has addr 20. clear_err then clears it.
5. FIFO full, out_ready = 1 on the push cycle -> word stored, overflow stays 0, count stays 16.
6. With LCD_CAPTURE_DOUBLE_BUFFER_EN:
   - Second frame's first word addr = 2880.
   - bank = 0 after the first frame completes, 1 after the second.
   - Without the macro, the second frame's first addr = 0.
